// File: rtl/dbus_responder.sv
`default_nettype none
// ============================================================================
// dbus_responder : fixed-latency data-bus responder with byte-lane word store
// Revision 1.0
// ============================================================================

package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

module dbus_responder
    import dbus_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       busy
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [3:0] c_CNT_LOAD    = 4'(LATENCY - 1);
    localparam logic [1:0] c_ACCEPT_NEXT = (LATENCY == 1) ? c_RESP : c_WAIT;

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic [3:0]    r_strobe;
    logic [31:0]   r_wdata;
    logic [31:0]   r_mem [MEM_WORDS];

    logic w_accept;
    logic w_complete;
    logic w_write;
    logic w_unused_bits;

    // Outputs are gated by reset so a cycle with reset held high is always quiet.
    assign w_accept      = !reset && (r_state == c_IDLE) && dreq.valid;
    assign w_complete    = !reset && (r_state == c_RESP) && dreq.valid;
    assign w_write       = w_complete && (r_strobe != 4'b0000);
    assign w_unused_bits = ^{dreq.size, dreq.addr[31:AW+2], dreq.addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= 4'd0;
            r_idx    <= '0;
            r_strobe <= 4'd0;
            r_wdata  <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (dreq.valid) begin
                        r_idx    <= dreq.addr[AW+1:2];
                        r_strobe <= dreq.strobe;
                        r_wdata  <= dreq.data;
                        r_cnt    <= c_CNT_LOAD;
                        r_state  <= c_ACCEPT_NEXT;
                    end
                end
                c_WAIT: begin
                    if (!dreq.valid) begin
                        r_cnt   <= 4'd0;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state <= c_RESP;
                        end
                    end
                end
                c_RESP: begin
                    r_cnt   <= 4'd0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_cnt   <= 4'd0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; only a completed write changes it.
    always_ff @(posedge clk) begin
        if (w_write) begin
            for (int i = 0; i < 4; i++) begin
                if (r_strobe[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = w_accept;
        dresp.data_ok = w_complete;
        if (w_complete && (r_strobe == 4'b0000)) begin
            dresp.data = r_mem[r_idx];
        end
    end

    assign busy = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dbus_responder.sv
`default_nettype none
// ============================================================================
// tb_dbus_responder : scoreboard bench for dbus_responder with a word-array model
// Revision 1.0
// ============================================================================

module tb_dbus_responder;
    import dbus_pkg::*;

    localparam int LAT   = 2;
    localparam int WORDS = 1024;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       busy;

    dbus_responder #(
        .MEM_WORDS (WORDS),
        .LATENCY   (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dreq  (dreq),
        .dresp (dresp),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [WORDS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every data_ok must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (dresp.data_ok === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("data_ok_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_data", dresp.data, e.data);
                chk("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else begin
            chk("idle_data_zero", dresp.data, 32'd0);
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                void'(exp_q.pop_front());
                chk("data_ok_missing", 32'd0, 32'd1);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with valid low. abort_at=k drops
    // valid in the k-th cycle after acceptance.
    task automatic txn(input logic [31:0] addr, input logic [3:0] strobe,
                       input logic [31:0] data, input int abort_at, output int t_acc);
        int   idx;
        exp_t e;
        dreq.valid  = 1'b1;
        dreq.addr   = addr;
        dreq.strobe = strobe;
        dreq.data   = data;
        dreq.size   = 2'($urandom_range(0, 3));
        idx = int'((addr >> 2) % 32'(WORDS));
        @(negedge clk);
        chk("addr_ok_accept", 32'(dresp.addr_ok), 32'd1);
        t_acc = cyc;
        if (abort_at == 0) begin
            if (strobe == 4'b0000) begin
                e.data = model[idx];
            end else begin
                e.data = 32'd0;
                for (int b = 0; b < 4; b++)
                    if (strobe[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            end
            e.cyc = t_acc + LAT;
            exp_q.push_back(e);
        end
        for (int i = 1; i <= LAT; i++) begin
            @(posedge clk); #1;
            dreq.addr   = $urandom;
            dreq.data   = $urandom;
            dreq.strobe = 4'($urandom);
            dreq.size   = 2'($urandom_range(0, 3));
            if (i == abort_at) dreq.valid = 1'b0;
            @(negedge clk);
            chk("busy_in_txn", 32'(busy), 32'd1);
            chk("addr_ok_held_low", 32'(dresp.addr_ok), 32'd0);
            if (i == abort_at) break;
        end
        @(posedge clk); #1;
        dreq.valid = 1'b0;
        if (abort_at != 0) begin
            @(negedge clk);
            chk("busy_after_abort", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          t0, t1, t2;
        logic [31:0] r;
        reset = 1'b1;
        dreq  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_addr_ok", 32'(dresp.addr_ok), 32'd0);
        chk("reset_data_ok", 32'(dresp.data_ok), 32'd0);
        chk("reset_data", dresp.data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 16; i++) txn(32'(i) << 2, 4'hF, $urandom, 0, t0);

        // Full write then read back, partial write merge.
        txn(32'h10, 4'hF, 32'hDEADBEEF, 0, t0);
        txn(32'h10, 4'h0, 32'h0, 0, t0);
        txn(32'h10, 4'b0001, 32'h000000AA, 0, t0);
        txn(32'h10, 4'h0, 32'h0, 0, t0);

        // Back-to-back reads with valid never low at a clock edge.
        txn(32'h10, 4'h0, 32'h0, 0, t1);
        txn(32'h20, 4'h0, 32'h0, 0, t2);
        chk("b2b_spacing", 32'(t2 - t1), 32'(LAT + 1));

        // Aborted writes in WAIT and in RESP leave storage untouched.
        txn(32'h20, 4'hF, 32'h55AA55AA, 1, t0);
        txn(32'h20, 4'h0, 32'h0, 0, t0);
        txn(32'h20, 4'hF, 32'h3C3C3C3C, 2, t0);
        txn(32'h20, 4'h0, 32'h0, 0, t0);

        // Reset during WAIT discards the write.
        dreq.valid  = 1'b1;
        dreq.addr   = 32'h30;
        dreq.strobe = 4'hF;
        dreq.data   = 32'h12345678;
        @(negedge clk);
        chk("rst_txn_accept", 32'(dresp.addr_ok), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_addr_ok", 32'(dresp.addr_ok), 32'd0);
        chk("rst_mid_data_ok", 32'(dresp.data_ok), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        txn(32'h30, 4'h0, 32'h0, 0, t0);

        // Address wrap modulo MEM_WORDS.
        txn(32'h1000_0004, 4'hF, 32'hCAFEF00D, 0, t0);
        txn(32'h0000_0004, 4'h0, 32'h0, 0, t0);

        for (int n = 0; n < 150; n++) begin
            logic [3:0] stb;
            int         ab;
            r   = $urandom;
            r   = (r & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
            stb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            ab  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, LAT) : 0;
            txn(r, stb, $urandom, ab, t0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning the number of 32-bit storage words (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the cycles from request acceptance to data_ok (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port dreq, input, dbus_req_t: the initiator request, with fields valid, addr[31:0], size, strobe[3:0] and data[31:0].
REQ-006 SHALL have port dresp, output, dbus_resp_t: the responder reply, with fields addr_ok, data_ok and data[31:0].
REQ-007 SHALL have port busy, output, 1 bit: high while a transaction is accepted and not yet completed.

Function
REQ-008 SHALL implement FSM states IDLE, WAIT and RESP; reset state is IDLE.
REQ-009 In IDLE with dreq.valid=1, SHALL assert dresp.addr_ok for that cycle only, latch addr, strobe and data, load the counter with LATENCY-1, and move to WAIT (or to RESP when LATENCY=1).
REQ-010 In IDLE with dreq.valid=0, SHALL hold addr_ok=0 and data_ok=0.
REQ-011 In WAIT, SHALL decrement the counter each cycle and move to RESP when the counter reaches 1.
REQ-012 In RESP, SHALL assert dresp.data_ok for exactly one cycle, then return to IDLE.
REQ-013 Latency: if accepted in cycle T, data_ok SHALL be asserted in cycle T+LATENCY.
REQ-014 Back-to-back requests: SHALL NOT accept a new request in the RESP cycle; the earliest next addr_ok is RESP+1.
REQ-015 Word index SHALL be latched addr[log2(MEM_WORDS)+1:2]; higher address bits are ignored (wrap modulo MEM_WORDS); addr[1:0] is ignored for indexing.
REQ-016 Read (latched strobe==4'b0000): dresp.data in the RESP cycle SHALL equal the full stored word; the initiator extracts bytes by size and offset.
REQ-017 Write (strobe!=0): in the RESP cycle SHALL update byte lane i with data[8i+7:8i] only when strobe[i]=1; dresp.data SHALL be 0.
REQ-018 A read following a write to the same word SHALL return the updated value.
REQ-019 Outside the RESP cycle, dresp.data SHALL be 0.
REQ-020 During WAIT and RESP, SHALL use only the latched request fields; changes to dreq.addr, dreq.strobe and dreq.data are ignored.
REQ-021 Abort: if dreq.valid=0 in any WAIT or RESP cycle, SHALL suppress data_ok, SHALL NOT perform any pending write, and SHALL return to IDLE next cycle.
REQ-022 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.
REQ-023 size SHALL NOT affect behaviour; strobe alone determines write lanes.

Reset
REQ-024 On reset=1 at a clock edge, SHALL go to IDLE, clear the counter, and drive addr_ok=0, data_ok=0, dresp.data=0 and busy=0 the following cycle.
REQ-025 Reset mid-transaction SHALL discard the pending request, with no write and no data_ok.
REQ-026 Storage contents SHALL NOT be cleared by reset.
REQ-027 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-028 Bench SHALL cover: LATENCY=2; write addr=0x10, data=0xDEADBEEF, strobe=4'hF accepted at T -> addr_ok at T, data_ok at T+2; then read 0x10 -> data=0xDEADBEEF.
REQ-029 Bench SHALL cover: partial write addr=0x10, data=0x000000AA, strobe=4'b0001 over 0xDEADBEEF -> subsequent read returns 0xDEADBEAA.
REQ-030 Bench SHALL cover: valid held continuously for two reads -> second addr_ok exactly one cycle after the first data_ok; each data_ok is one cycle wide.
REQ-031 Bench SHALL cover: write to 0x20 with valid dropped in WAIT -> no data_ok; a later read of 0x20 returns the prior contents.
REQ-032 Bench SHALL cover: reset asserted in WAIT -> next cycle busy=0, addr_ok=0, data_ok=0; a new request is accepted in the first cycle after reset deasserts.
REQ-033 Bench SHALL cover: MEM_WORDS=1024, write addr=0x1000_0004 then read addr=0x0000_0004 -> identical data (wrap).
